// File: rtl/dcache_flush_walker.sv
// Data-cache maintenance walker: sweeps every set/way of the tag array, writing
// back dirty lines and invalidating all lines; also runs the post-reset invalidate.
module dcache_flush_walker #(
  parameter int NUM_SETS = 256,
  parameter int NUM_WAYS = 8,
  parameter int SET_W    = $clog2(NUM_SETS),
  parameter int WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  output logic             flush_ack_o,
  input  logic             init_skip_i,
  output logic             busy_o,
  output logic             tag_req_o,
  output logic             tag_we_o,
  output logic [SET_W-1:0] tag_set_o,
  output logic [WAY_W-1:0] tag_way_o,
  input  logic             tag_gnt_i,
  input  logic             tag_valid_i,
  input  logic             tag_dirty_i,
  output logic             wb_req_o,
  input  logic             wb_gnt_i,
  input  logic             wb_done_i
);

  localparam logic [3:0] BOOT    = 4'd0;
  localparam logic [3:0] IDLE    = 4'd1;
  localparam logic [3:0] INIT    = 4'd2;
  localparam logic [3:0] READ    = 4'd3;
  localparam logic [3:0] CHECK   = 4'd4;
  localparam logic [3:0] WB_REQ  = 4'd5;
  localparam logic [3:0] WB_WAIT = 4'd6;
  localparam logic [3:0] INV     = 4'd7;
  localparam logic [3:0] ACK     = 4'd8;
  localparam logic [3:0] HOLD    = 4'd9;

  localparam logic [SET_W-1:0] LAST_SET = SET_W'(NUM_SETS - 1);
  localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(NUM_WAYS - 1);

  logic [3:0]       state;
  logic [3:0]       state_next;
  logic [SET_W-1:0] set_idx;
  logic [WAY_W-1:0] way_idx;
  logic             last_line;
  logic             advance;
  logic             clear_cnt;

  assign last_line = (set_idx == LAST_SET) && (way_idx == LAST_WAY);

  always_comb begin
    state_next = state;
    advance    = 1'b0;
    clear_cnt  = 1'b0;
    case (state)
      BOOT: state_next = init_skip_i ? IDLE : INIT;
      IDLE: begin
        if (flush_i) begin
          state_next = READ;
          clear_cnt  = 1'b1;
        end
      end
      INIT: begin
        if (tag_gnt_i) begin
          advance = 1'b1;
          if (last_line) begin
            state_next = IDLE;
            clear_cnt  = 1'b1;
          end
        end
      end
      READ: begin
        if (tag_gnt_i) state_next = CHECK;
      end
      // Tag read data arrives exactly one cycle after the read grant.
      CHECK: begin
        if (!tag_valid_i) begin
          advance    = 1'b1;
          state_next = last_line ? ACK : READ;
        end else if (tag_dirty_i) begin
          state_next = WB_REQ;
        end else begin
          state_next = INV;
        end
      end
      WB_REQ: begin
        if (wb_gnt_i) state_next = WB_WAIT;
      end
      WB_WAIT: begin
        if (wb_done_i) state_next = INV;
      end
      INV: begin
        if (tag_gnt_i) begin
          advance    = 1'b1;
          state_next = last_line ? ACK : READ;
        end
      end
      ACK: begin
        state_next = HOLD;
        clear_cnt  = 1'b1;
      end
      // Wait out the controller's registered lag so one request yields one flush.
      HOLD: begin
        if (!flush_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= BOOT;
      set_idx <= '0;
      way_idx <= '0;
    end else begin
      state <= state_next;
      if (clear_cnt) begin
        set_idx <= '0;
        way_idx <= '0;
      end else if (advance) begin
        if (way_idx == LAST_WAY) begin
          way_idx <= '0;
          set_idx <= set_idx + SET_W'(1);
        end else begin
          way_idx <= way_idx + WAY_W'(1);
        end
      end
    end
  end

  assign tag_req_o   = (state == INIT) || (state == READ) || (state == INV);
  assign tag_we_o    = (state == INIT) || (state == INV);
  assign tag_set_o   = set_idx;
  assign tag_way_o   = way_idx;
  assign wb_req_o    = (state == WB_REQ);
  assign flush_ack_o = (state == ACK);
  // Qualified by reset so every output reads 0 while reset is held, BOOT included.
  assign busy_o      = rst_ni && (state != IDLE);

endmodule
